// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two framed byte
// requesters, round-robin between frames, with a per-byte watchdog.
module uart_tx_arbiter #(
    parameter logic [15:0] WDOG = 16'd50000
) (
    input  logic       top_clk,
    input  logic       top_rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ack0,
    output logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       tx_start,
    output logic [7:0] tx_bus,
    input  logic       tx_done_tick,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt;
    logic        r_owner;
    logic        r_rr;
    logic        r_last;
    logic [7:0]  r_tx_bus;
    logic [15:0] r_wdog;

    logic        w_gnt_nxt;
    logic        w_owner_nxt;
    logic        w_rr_nxt;
    logic        w_load;
    logic        w_err;
    logic        w_pick;
    logic        w_own_req;
    logic        w_expire;
    logic [7:0]  w_sel_data;
    logic        w_sel_last;

    // Contention goes to the rr pointer; a lone request wins outright.
    always_comb begin
        w_pick = r_rr;
        if (req0 && !req1) begin
            w_pick = 1'b0;
        end else if (req1 && !req0) begin
            w_pick = 1'b1;
        end
    end

    assign w_own_req  = r_owner ? req1 : req0;
    assign w_expire   = (r_wdog == WDOG - 16'd1);
    assign w_sel_data = w_owner_nxt ? data1 : data0;
    assign w_sel_last = w_owner_nxt ? last1 : last0;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_load      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done tick on the expiry cycle still completes the byte.
                if (tx_done_tick) begin
                    if (r_last) begin
                        w_gnt_nxt   = 1'b0;
                        w_rr_nxt    = ~r_owner;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end else if (w_expire) begin
                    w_err       = 1'b1;
                    w_gnt_nxt   = 1'b0;
                    w_rr_nxt    = ~r_owner;
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT: begin
                if (w_own_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= 1'b0;
            r_owner  <= 1'b0;
            r_rr     <= 1'b0;
            r_last   <= 1'b0;
            r_tx_bus <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            if (w_load) begin
                r_tx_bus <= w_sel_data;
                r_last   <= w_sel_last;
            end
        end
    end

    // Saturating so a very large WDOG can never wrap the count.
    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            r_wdog <= 16'd0;
        end else if (r_state == S_START) begin
            r_wdog <= 16'd0;
        end else if (r_state == S_WAIT && r_wdog != 16'hFFFF) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    assign tx_start = (r_state == S_START);
    assign ack0     = tx_start && !r_owner;
    assign ack1     = tx_start && r_owner;
    assign gnt0     = r_gnt && !r_owner;
    assign gnt1     = r_gnt && r_owner;
    assign tx_bus   = r_tx_bus;
    assign err      = w_err;

    a_one_gnt: assert property (
        @(posedge top_clk) disable iff (!top_rst_n) !(gnt0 && gnt1));
    a_one_ack: assert property (
        @(posedge top_clk) disable iff (!top_rst_n) !(ack0 && ack1));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and UART models feed a byte
// scoreboard and an expected grant-order queue.
module tb_uart_tx_arbiter;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } byte_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       last0 = 1'b0;
    logic       last1 = 1'b0;
    logic       ack0, ack1, gnt0, gnt1, tx_start, err;
    logic [7:0] tx_bus;
    logic       tick_m = 1'b0;
    logic       spur   = 1'b0;
    logic       tx_done_tick;

    assign tx_done_tick = tick_m | spur;

    int         n_chk = 0;
    int         n_err = 0;
    byte_t      drv_q0[$];
    byte_t      drv_q1[$];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         gq[$];
    int         starts[$];
    bit         hold0   = 1'b0;
    bit         hold1   = 1'b0;
    bit         uart_en = 1'b1;
    int         lat = 10;
    int         cd  = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         ack0_cnt  = 0;
    int         ack1_cnt  = 0;
    int         err_cnt   = 0;
    int         tick_cyc  = -100;
    int         gfall_cyc = -100;
    int         err_cyc   = -100;
    int         start_cyc = -100;
    logic       prev_start = 1'b0;
    logic [1:0] prev_gnt   = 2'b00;
    int         cur_owner  = 0;

    uart_tx_arbiter #(.WDOG(16'd16)) dut (
        .top_clk      (clk),
        .top_rst_n    (rst_n),
        .req0         (req0),
        .req1         (req1),
        .data0        (data0),
        .data1        (data1),
        .last0        (last0),
        .last1        (last1),
        .ack0         (ack0),
        .ack1         (ack1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .tx_start     (tx_start),
        .tx_bus       (tx_bus),
        .tx_done_tick (tx_done_tick),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic byte_t mk(input logic [7:0] d, input logic l);
        byte_t b;
        b.d = d;
        b.l = l;
        return b;
    endfunction

    // One clock: UART and requester models act on the falling edge,
    // then outputs are sampled 1 ns later.
    task automatic step();
        byte_t b;
        @(negedge clk);
        tick_m = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) tick_m = 1'b1;
        end else if (tx_start && uart_en) begin
            cd = lat;
        end
        if (req0 && ack0) req0 = 1'b0;
        if (!req0 && !hold0 && drv_q0.size() > 0) begin
            b = drv_q0.pop_front();
            req0 = 1'b1;
            data0 = b.d;
            last0 = b.l;
            exp_q0.push_back(b.d);
        end
        if (req1 && ack1) req1 = 1'b0;
        if (!req1 && !hold1 && drv_q1.size() > 0) begin
            b = drv_q1.pop_front();
            req1 = 1'b1;
            data1 = b.d;
            last1 = b.l;
            exp_q1.push_back(b.d);
        end
        #1;
        cyc++;
        if (tick_m) tick_cyc = cyc;
        if (prev_gnt == 2'b00 && {gnt1, gnt0} != 2'b00) begin
            if (gq.size() == 0) begin
                check("grant_unexp", 32'({gnt1, gnt0}), 0);
            end else begin
                cur_owner = gq.pop_front();
                check("grant", 32'({gnt1, gnt0}), cur_owner != 0 ? 2 : 1);
            end
        end else if (prev_gnt != 2'b00 && {gnt1, gnt0} != 2'b00 &&
                     {gnt1, gnt0} != prev_gnt) begin
            check("gnt_switch", 32'({gnt1, gnt0}), 32'(prev_gnt));
        end
        if (prev_gnt != 2'b00 && {gnt1, gnt0} == 2'b00) gfall_cyc = cyc;
        if (tx_start) begin
            start_cnt++;
            start_cyc = cyc;
            starts.push_back(cyc);
            check("start_b2b", 32'(prev_start), 0);
            check("ack", 32'({ack1, ack0}), cur_owner != 0 ? 2 : 1);
            if (tick_cyc > 0) check("gap_min", 32'((cyc - tick_cyc) >= 2), 1);
            if (cur_owner == 0) begin
                if (exp_q0.size() == 0) check("exp0_empty", 1, 0);
                else check("byte0", 32'(tx_bus), 32'(exp_q0.pop_front()));
            end else begin
                if (exp_q1.size() == 0) check("exp1_empty", 1, 0);
                else check("byte1", 32'(tx_bus), 32'(exp_q1.pop_front()));
            end
        end else if ({ack1, ack0} != 2'b00) begin
            check("ack_stray", 32'({ack1, ack0}), 0);
        end
        if (ack0) ack0_cnt++;
        if (ack1) ack1_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        prev_start = tx_start;
        prev_gnt = {gnt1, gnt0};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (n < max && !(drv_q0.size() == 0 && drv_q1.size() == 0 &&
               !req0 && !req1 && !gnt0 && !gnt1 && cd == 0)) begin
            step();
            n++;
        end
        check(tag, 32'(n >= max), 0);
    endtask

    task automatic wait_start(input string tag, input int max);
        int n = 0;
        int s = start_cnt;
        while (n < max && start_cnt == s) begin
            step();
            n++;
        end
        check(tag, 32'(start_cnt == s), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check(tag, 32'({ack0, ack1, gnt0, gnt1, tx_start, err, tx_bus}), 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int a0, a1, s0, e0, rc;
        #2;
        do_reset("rst_out");

        // Single requester, 3-byte frame.
        starts.delete();
        a0 = ack0_cnt;
        drv_q0.push_back(mk(8'h41, 1'b0));
        drv_q0.push_back(mk(8'h42, 1'b0));
        drv_q0.push_back(mk(8'h43, 1'b1));
        gq.push_back(0);
        drain("s1_done", 200);
        check("s1_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            check("s1_gap1", starts[1] - starts[0], 12);
            check("s1_gap2", starts[2] - starts[1], 12);
        end
        check("s1_acks", ack0_cnt - a0, 3);
        check("s1_gfall", gfall_cyc - tick_cyc, 1);

        // Both requesting from reset: order 0,1,0,1.
        drv_q0.push_back(mk(8'h10, 1'b1));
        drv_q0.push_back(mk(8'h11, 1'b1));
        drv_q1.push_back(mk(8'h20, 1'b1));
        drv_q1.push_back(mk(8'h21, 1'b1));
        gq.push_back(0);
        gq.push_back(1);
        gq.push_back(0);
        gq.push_back(1);
        do_reset("rst_out2");
        drain("s2_done", 400);
        check("s2_order_left", gq.size(), 0);

        // Requester 1 waits while requester 0 stalls between bytes.
        drv_q0.push_back(mk(8'h30, 1'b0));
        drv_q0.push_back(mk(8'h31, 1'b1));
        gq.push_back(0);
        gq.push_back(1);
        step();
        hold0 = 1'b1;
        wait_start("s3_first", 20);
        a1 = ack1_cnt;
        drv_q1.push_back(mk(8'h40, 1'b1));
        run(30);
        check("s3_no_ack1", ack1_cnt - a1, 0);
        check("s3_gnt0_held", 32'({gnt1, gnt0}), 1);
        hold0 = 1'b0;
        drain("s3_done", 200);
        check("s3_ack1", ack1_cnt - a1, 1);

        // Watchdog expiry, then the other requester's frame.
        uart_en = 1'b0;
        e0 = err_cnt;
        drv_q0.push_back(mk(8'h50, 1'b1));
        drv_q1.push_back(mk(8'h60, 1'b1));
        gq.push_back(0);
        gq.push_back(1);
        for (int i = 0; i < 60 && err_cnt == e0; i++) step();
        check("s4_err_seen", 32'(err_cnt != e0), 1);
        check("s4_err_lat", err_cyc - start_cyc, 16);
        uart_en = 1'b1;
        step();
        check("s4_gnt_clr", 32'({gnt1, gnt0}), 0);
        drain("s4_done", 200);
        check("s4_err_once", err_cnt - e0, 1);
        check("s4_order_left", gq.size(), 0);

        // Spurious done ticks in IDLE and NEXT.
        s0 = start_cnt;
        a0 = ack0_cnt + ack1_cnt;
        spur = 1'b1;
        step();
        spur = 1'b0;
        run(3);
        check("s5_idle_start", start_cnt - s0, 0);
        check("s5_idle_ack", ack0_cnt + ack1_cnt - a0, 0);
        check("s5_idle_gnt", 32'({gnt1, gnt0}), 0);
        drv_q1.push_back(mk(8'h70, 1'b0));
        drv_q1.push_back(mk(8'h71, 1'b1));
        gq.push_back(1);
        step();
        hold1 = 1'b1;
        wait_start("s5_first", 20);
        run(12);
        check("s5_in_next", 32'({gnt1, gnt0}), 2);
        s0 = start_cnt;
        spur = 1'b1;
        step();
        spur = 1'b0;
        run(3);
        check("s5_next_start", start_cnt - s0, 0);
        check("s5_next_gnt", 32'({gnt1, gnt0}), 2);
        hold1 = 1'b0;
        drain("s5_done", 200);

        // Reset while waiting on the UART; its late tick is ignored.
        e0 = err_cnt;
        drv_q0.push_back(mk(8'h80, 1'b1));
        gq.push_back(0);
        wait_start("s6_first", 20);
        run(3);
        rc = cyc;
        do_reset("s6_rst_async");
        s0 = start_cnt;
        run(15);
        check("s6_late_tick", 32'(tick_cyc > rc), 1);
        check("s6_no_err", err_cnt - e0, 0);
        check("s6_no_start", start_cnt - s0, 0);
        check("s6_gnt", 32'({gnt1, gnt0}), 0);

        check("exp_left", exp_q0.size() + exp_q1.size(), 0);
        check("gq_left", gq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
